// File: rtl/card_dealer.sv
// Draw/hand-tracking stage for the card game FSM: draws ranks from an LFSR and keeps saturating high/low hand totals.
// Optional macro CARD_DEALER_DECK_TRACK_EN tracks a 52-card deck so each rank is dealt at most 4 times per shuffle.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SAT_MAX   = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] userSelect,
  input  logic       clearHands,
  input  logic       overrideEn,
  input  logic [3:0] overrideRank,
  output logic [4:0] p1_high,
  output logic [4:0] p1_low,
  output logic [4:0] p2_high,
  output logic [4:0] p2_low,
  output logic [4:0] d_high,
  output logic [4:0] d_low,
  output logic       cardsUpdated,
  output logic [3:0] lastRank,
  output logic [1:0] lastTarget
);

  typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE, DONE} state_t;

  localparam logic [5:0] SAT = 6'(SAT_MAX);

  state_t      state;
  logic [15:0] lfsr;
  logic [1:0]  target;
  logic [3:0]  rank_q;
  logic [4:0]  low_q  [3];
  logic [4:0]  high_q [3];
  logic        ace_q  [3];

  logic [3:0] sample_rank;
  logic       rank_legal;
  logic       rank_avail;
  logic [1:0] hidx;
  logic [3:0] points;
  logic [5:0] low_sum;
  logic [4:0] new_low;
  logic       new_ace;
  logic [5:0] high_sum;
  logic [4:0] new_high;

  assign sample_rank = overrideEn ? overrideRank : lfsr[3:0];
  assign rank_legal  = (sample_rank >= 4'd1) && (sample_rank <= 4'd13);

`ifdef CARD_DEALER_DECK_TRACK_EN
  logic [2:0] deck_cnt [16];
  logic [5:0] deck_total;
  // A forced rank is dealt even when its count is exhausted; the decrement then saturates.
  assign rank_avail = overrideEn || (deck_cnt[sample_rank] != 3'd0);
`else
  assign rank_avail = 1'b1;
`endif

  // Totals for the latched hand after adding the card held in rank_q; only one ace ever counts as 11.
  assign hidx     = target - 2'd1;
  assign points   = (rank_q > 4'd10) ? 4'd10 : rank_q;
  assign low_sum  = {1'b0, low_q[hidx]} + {2'b00, points};
  assign new_low  = (low_sum > SAT) ? SAT[4:0] : low_sum[4:0];
  assign new_ace  = ace_q[hidx] | (rank_q == 4'd1);
  assign high_sum = {1'b0, new_low} + 6'd10;
  assign new_high = !new_ace ? new_low : ((high_sum > SAT) ? SAT[4:0] : high_sum[4:0]);

  assign p1_low  = low_q[0];
  assign p1_high = high_q[0];
  assign p2_low  = low_q[1];
  assign p2_high = high_q[1];
  assign d_low   = low_q[2];
  assign d_high  = high_q[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      target       <= 2'd0;
      rank_q       <= 4'd0;
      cardsUpdated <= 1'b0;
      lastRank     <= 4'd0;
      lastTarget   <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        low_q[i]  <= 5'd0;
        high_q[i] <= 5'd0;
        ace_q[i]  <= 1'b0;
      end
`ifdef CARD_DEALER_DECK_TRACK_EN
      deck_total <= 6'd52;
      for (int i = 0; i < 16; i++) deck_cnt[i] <= (i >= 1 && i <= 13) ? 3'd4 : 3'd0;
`endif
    end else begin
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cardsUpdated <= 1'b0;
      if (clearHands) begin
        state      <= IDLE;
        lastRank   <= 4'd0;
        lastTarget <= 2'd0;
        for (int i = 0; i < 3; i++) begin
          low_q[i]  <= 5'd0;
          high_q[i] <= 5'd0;
          ace_q[i]  <= 1'b0;
        end
`ifdef CARD_DEALER_DECK_TRACK_EN
        deck_total <= 6'd52;
        for (int i = 0; i < 16; i++) deck_cnt[i] <= (i >= 1 && i <= 13) ? 3'd4 : 3'd0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (userSelect != 2'd0) begin
              target <= userSelect;
              state  <= SAMPLE;
            end
          end
          SAMPLE: begin
            if (rank_legal && rank_avail) begin
              rank_q <= sample_rank;
              state  <= UPDATE;
            end
          end
          UPDATE: begin
            low_q[hidx]  <= new_low;
            high_q[hidx] <= new_high;
            ace_q[hidx]  <= new_ace;
            lastRank     <= rank_q;
            lastTarget   <= target;
            cardsUpdated <= 1'b1;
            state        <= DONE;
`ifdef CARD_DEALER_DECK_TRACK_EN
            if (deck_cnt[rank_q] != 3'd0) begin
              if (deck_total == 6'd1) begin
                deck_total <= 6'd52;
                for (int i = 0; i < 16; i++) deck_cnt[i] <= (i >= 1 && i <= 13) ? 3'd4 : 3'd0;
              end else begin
                deck_total       <= deck_total - 6'd1;
                deck_cnt[rank_q] <= deck_cnt[rank_q] - 3'd1;
              end
            end
`endif
          end
          // Hold off re-arming until the FSM drops its late userSelect.
          DONE: begin
            if (userSelect == 2'd0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: draw tasks push expected hand totals, a negedge monitor pops them on each cardsUpdated pulse.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] userSelect;
  logic       clearHands;
  logic       overrideEn;
  logic [3:0] overrideRank;
  logic [4:0] p1_high, p1_low, p2_high, p2_low, d_high, d_low;
  logic       cardsUpdated;
  logic [3:0] lastRank;
  logic [1:0] lastTarget;

  card_dealer dut (
    .clk(clk), .reset(reset), .userSelect(userSelect), .clearHands(clearHands),
    .overrideEn(overrideEn), .overrideRank(overrideRank),
    .p1_high(p1_high), .p1_low(p1_low), .p2_high(p2_high), .p2_low(p2_low),
    .d_high(d_high), .d_low(d_low), .cardsUpdated(cardsUpdated),
    .lastRank(lastRank), .lastTarget(lastTarget)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][4:0] t;
    logic [3:0]      rank;
    logic [1:0]      tgt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_low [3];
  bit   m_ace [3];
  bit   prev_cu = 1'b0;
  bit   deck_mode = 1'b0;
  int   tally [16];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  // Reference arithmetic: add a card to the model hand and queue the expected outputs.
  task automatic pushExpect(input int tgt, input int rank);
    exp_t e;
    int   h, hi;
    h = tgt - 1;
    m_low[h] = sat(m_low[h] + ((rank > 10) ? 10 : rank));
    if (rank == 1) m_ace[h] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hi = m_ace[i] ? sat(m_low[i] + 10) : m_low[i];
      e.t[2*i]   = 5'(hi);
      e.t[2*i+1] = 5'(m_low[i]);
    end
    e.rank = 4'(rank);
    e.tgt  = 2'(tgt);
    sb.push_back(e);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      m_low[i] = 0;
      m_ace[i] = 1'b0;
    end
  endtask

  task automatic waitPulse(input string name, input int budget);
    int n = 0;
    while (!cardsUpdated && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic applyStimulus(input int tgt, input int rank, input int hold);
    @(negedge clk);
    overrideEn   = 1'b1;
    overrideRank = 4'(rank);
    userSelect   = 2'(tgt);
    pushExpect(tgt, rank);
    waitPulse("draw", 20);
    repeat (hold) @(negedge clk);
    userSelect = 2'd0;
    repeat (2) @(negedge clk);
  endtask

  // Pulse must be absent two negedges after the request and present on the third.
  task automatic latencyDraw(input int tgt, input int rank);
    @(negedge clk);
    overrideEn   = 1'b1;
    overrideRank = 4'(rank);
    userSelect   = 2'(tgt);
    pushExpect(tgt, rank);
    @(negedge clk) checkOutput("lat_n1", cardsUpdated, 0);
    @(negedge clk) checkOutput("lat_n2", cardsUpdated, 0);
    @(negedge clk) checkOutput("lat_n3", cardsUpdated, 1);
    userSelect = 2'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_p1_high"}, p1_high, 0);
    checkOutput({name, "_p1_low"}, p1_low, 0);
    checkOutput({name, "_p2_high"}, p2_high, 0);
    checkOutput({name, "_p2_low"}, p2_low, 0);
    checkOutput({name, "_d_high"}, d_high, 0);
    checkOutput({name, "_d_low"}, d_low, 0);
    checkOutput({name, "_cardsUpdated"}, cardsUpdated, 0);
    checkOutput({name, "_lastRank"}, lastRank, 0);
    checkOutput({name, "_lastTarget"}, lastTarget, 0);
  endtask

  // Monitor: every pulse is one cycle wide and must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (cardsUpdated) begin
        checkOutput("pulse_width", int'(prev_cu), 0);
        if (deck_mode) begin
          tally[lastRank] = tally[lastRank] + 1;
        end else if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("p1_high", p1_high, e.t[0]);
          checkOutput("p1_low", p1_low, e.t[1]);
          checkOutput("p2_high", p2_high, e.t[2]);
          checkOutput("p2_low", p2_low, e.t[3]);
          checkOutput("d_high", d_high, e.t[4]);
          checkOutput("d_low", d_low, e.t[5]);
          checkOutput("lastRank", lastRank, e.rank);
          checkOutput("lastTarget", lastTarget, e.tgt);
        end
      end
      prev_cu <= cardsUpdated;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    userSelect   = 2'd0;
    clearHands   = 1'b0;
    overrideEn   = 1'b0;
    overrideRank = 4'd0;
    clearModel();
    for (int i = 0; i < 16; i++) tally[i] = 0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Ace to P1 with latency check: low 1, high 11.
    latencyDraw(1, 1);
    // K then A: 11/21, then 12/22 (second ace counts as 1).
    applyStimulus(1, 13, 0);
    applyStimulus(1, 1, 0);
    // Dealer four tens: 10, 20, 30, then saturated 31.
    for (int i = 0; i < 4; i++) applyStimulus(3, 10, 0);
    // Holding userSelect must not trigger a second draw; re-asserting does.
    applyStimulus(2, 7, 10);
    applyStimulus(2, 3, 0);

    // Illegal forced ranks retry without a pulse until a legal one appears.
    @(negedge clk);
    overrideRank = 4'd0;
    userSelect   = 2'd1;
    repeat (6) @(negedge clk);
    checkOutput("illegal_rank0", cardsUpdated, 0);
    overrideRank = 4'd14;
    repeat (3) @(negedge clk);
    checkOutput("illegal_rank14", cardsUpdated, 0);
    overrideRank = 4'd2;
    pushExpect(1, 2);
    waitPulse("illegal_recover", 20);
    userSelect = 2'd0;
    repeat (2) @(negedge clk);

    // Target latched in IDLE; a mid-draw change to P1 is ignored.
    @(negedge clk);
    overrideRank = 4'd4;
    userSelect   = 2'd2;
    pushExpect(2, 4);
    @(negedge clk);
    userSelect = 2'd1;
    waitPulse("midchange", 20);
    userSelect = 2'd0;
    repeat (2) @(negedge clk);

    // clearHands in the UPDATE cycle of a P2 draw wins: no pulse, everything zero.
    @(negedge clk);
    overrideRank = 4'd9;
    userSelect   = 2'd2;
    repeat (2) @(negedge clk);
    clearHands = 1'b1;
    @(negedge clk);
    clearHands = 1'b0;
    userSelect = 2'd0;
    clearModel();
    checkAllZero("clear_update");
    repeat (3) @(negedge clk);
    checkOutput("clear_nopulse", cardsUpdated, 0);
    // Back in IDLE: a fresh draw sees normal latency.
    latencyDraw(2, 1);
    applyStimulus(2, 1, 0);
    applyStimulus(2, 10, 0);
    applyStimulus(2, 10, 0);

    @(negedge clk);
    clearHands = 1'b1;
    @(negedge clk);
    clearHands = 1'b0;
    clearModel();
    checkAllZero("clear_idle");

`ifdef CARD_DEALER_DECK_TRACK_EN
    deck_mode  = 1'b1;
    overrideEn = 1'b0;
    for (int d = 0; d < 52; d++) begin
      @(negedge clk);
      userSelect = 2'd3;
      waitPulse("deck_draw", 3000);
      userSelect = 2'd0;
      repeat (2) @(negedge clk);
    end
    for (int r = 1; r <= 13; r++) checkOutput($sformatf("deck_rank%0d", r), tally[r], 4);
    @(negedge clk);
    userSelect = 2'd3;
    waitPulse("deck_reload", 3000);
    userSelect = 2'd0;
    repeat (2) @(negedge clk);
    deck_mode = 1'b0;
`endif

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
